// File: rtl/mem_access_pkg.sv
// Shared definitions for the wait-stated data-memory access block:
// FSM state encoding and access-counter width.
package mem_access_pkg;

    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_dmem_array.sv
// Word-addressed 32-bit data memory: asynchronous read, synchronous write.
// Contents are intentionally not reset.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_access.sv
// Wait-stated data-memory access controller: stalls upstream for WAIT_CYCLES
// cycles per load/store, then pulses done and commits any store.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; a request starts one (or completes it
//       | immediately when WAIT_CYCLES is 0)
// WAIT  | access in flight; cnt counts down, completion at cnt == 1
module mem_access
    import mem_access_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_to_reg_in,
    input  logic              mem_write_in,
    input  logic [ADDR_W-1:0] dmem_addr_in,
    input  logic [31:0]       dmem_in_in,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rd_data,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req;
    logic             stall_c, done_c, we_c;
    logic             we;

    assign req = mem_to_reg_in | mem_write_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        we_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && !flush) begin
                    if (WAIT_CYCLES == 0) begin
                        done_c = 1'b1;
                        we_c   = mem_write_in;
                    end else begin
                        stall_c   = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt > CNT_W'(1)) begin
                    stall_c = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    // Store data is still held by upstream because stall kept EXE_MEM frozen.
                    done_c    = 1'b1;
                    we_c      = mem_write_in;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs and the write strobe are gated so reset silences them immediately.
    assign stall = stall_c & rst;
    assign done  = done_c & rst;
    assign we    = we_c & rst;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_dmem_array (
        .clk   (clk),
        .we    (we),
        .addr  (dmem_addr_in),
        .wdata (dmem_in_in),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with three instances: WAIT_CYCLES = 2, 0, 1.
module tb_mem_access;

    logic clk = 1'b0;
    logic rst;

    logic        m2r_a, mw_a, flush_a, stall_a, done_a;
    logic [9:0]  addr_a;
    logic [31:0] din_a, rd_a;
    logic        m2r_b, mw_b, flush_b, stall_b, done_b;
    logic [9:0]  addr_b;
    logic [31:0] din_b, rd_b;
    logic        m2r_c, mw_c, flush_c, stall_c, done_c;
    logic [9:0]  addr_c;
    logic [31:0] din_c, rd_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_access #(.WAIT_CYCLES(2), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .mem_to_reg_in(m2r_a), .mem_write_in(mw_a),
        .dmem_addr_in(addr_a), .dmem_in_in(din_a), .flush(flush_a),
        .stall(stall_a), .rd_data(rd_a), .done(done_a)
    );

    mem_access #(.WAIT_CYCLES(0), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .mem_to_reg_in(m2r_b), .mem_write_in(mw_b),
        .dmem_addr_in(addr_b), .dmem_in_in(din_b), .flush(flush_b),
        .stall(stall_b), .rd_data(rd_b), .done(done_b)
    );

    mem_access #(.WAIT_CYCLES(1), .ADDR_W(10)) dut_c (
        .clk(clk), .rst(rst), .mem_to_reg_in(m2r_c), .mem_write_in(mw_c),
        .dmem_addr_in(addr_c), .dmem_in_in(din_c), .flush(flush_c),
        .stall(stall_c), .rd_data(rd_c), .done(done_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m2r_a = 0; mw_a = 0; flush_a = 0; addr_a = '0; din_a = '0;
        m2r_b = 0; mw_b = 0; flush_b = 0; addr_b = '0; din_b = '0;
        m2r_c = 0; mw_c = 0; flush_c = 0; addr_c = '0; din_c = '0;
    endtask

    task automatic store_a(input logic [9:0] a, input logic [31:0] d);
        mw_a = 1; m2r_a = 0; addr_a = a; din_a = d;
        repeat (3) tick();
        mw_a = 0; din_a = '0;
    endtask

    task automatic store_c(input logic [9:0] a, input logic [31:0] d);
        mw_c = 1; m2r_c = 0; addr_c = a; din_c = d;
        repeat (2) tick();
        mw_c = 0; din_c = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_all();
        m2r_a = 1; mw_b = 1; m2r_c = 1;
        #3;
        n_checks++;
        if ({stall_a, done_a, stall_b, done_b, stall_c, done_c} !== 6'b0)
            $display("FAIL reset_outputs: got %b, expected 000000",
                     {stall_a, done_a, stall_b, done_b, stall_c, done_c});
        else n_pass++;
        @(posedge clk);
        #2;
        n_checks++;
        if ({stall_a, done_a, stall_b, done_b, stall_c, done_c} !== 6'b0)
            $display("FAIL reset_after_edge: got %b, expected 000000",
                     {stall_a, done_a, stall_b, done_b, stall_c, done_c});
        else n_pass++;
        idle_all();
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_store_load();
        logic es [3] = '{1'b1, 1'b1, 1'b0};
        logic ed [3] = '{1'b0, 1'b0, 1'b1};
        mw_a = 1; m2r_a = 0; addr_a = 10'h005; din_a = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (stall_a !== es[i] || done_a !== ed[i])
                $display("FAIL store_wc2 cyc%0d: stall/done got %b%b, expected %b%b",
                         i, stall_a, done_a, es[i], ed[i]);
            else n_pass++;
            tick();
        end
        mw_a = 0; m2r_a = 1; din_a = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (stall_a !== es[i] || done_a !== ed[i])
                $display("FAIL load_wc2 cyc%0d: stall/done got %b%b, expected %b%b",
                         i, stall_a, done_a, es[i], ed[i]);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (rd_a !== 32'hDEADBEEF)
                    $display("FAIL load_wc2_data: got %h, expected deadbeef", rd_a);
                else n_pass++;
            end
            tick();
        end
        m2r_a = 0;
    endtask

    task automatic test_wait0();
        mw_b = 1; m2r_b = 0; addr_b = 10'h3FF; din_b = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if (stall_b !== 1'b0 || done_b !== 1'b1)
            $display("FAIL store_wc0: stall/done got %b%b, expected 01", stall_b, done_b);
        else n_pass++;
        tick();
        mw_b = 0; m2r_b = 1; din_b = '0;
        @(negedge clk);
        n_checks++;
        if (stall_b !== 1'b0 || done_b !== 1'b1 || rd_b !== 32'h12345678)
            $display("FAIL load_wc0: stall/done/data got %b%b %h, expected 01 12345678",
                     stall_b, done_b, rd_b);
        else n_pass++;
        tick();
        m2r_b = 0;
    endtask

    task automatic test_flush_idle();
        mw_b = 1; flush_b = 1; addr_b = 10'h3FF; din_b = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (stall_b !== 1'b0 || done_b !== 1'b0)
            $display("FAIL flush_idle: stall/done got %b%b, expected 00", stall_b, done_b);
        else n_pass++;
        tick();
        mw_b = 0; flush_b = 0; m2r_b = 1; din_b = '0;
        @(negedge clk);
        n_checks++;
        if (done_b !== 1'b1 || rd_b !== 32'h12345678)
            $display("FAIL flush_idle_data: done/data got %b %h, expected 1 12345678",
                     done_b, rd_b);
        else n_pass++;
        tick();
        m2r_b = 0;
    endtask

    task automatic test_flush();
        store_a(10'h010, 32'h00000001);
        mw_a = 1; addr_a = 10'h010; din_a = 32'hAAAA5555;
        @(negedge clk);
        n_checks++;
        if (stall_a !== 1'b1)
            $display("FAIL flush_stall1: stall got %b, expected 1", stall_a);
        else n_pass++;
        tick();
        flush_a = 1;
        @(negedge clk);
        n_checks++;
        if (stall_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL flush_wait: stall/done got %b%b, expected 00", stall_a, done_a);
        else n_pass++;
        tick();
        mw_a = 0; flush_a = 0; din_a = '0;
        @(negedge clk);
        n_checks++;
        if (stall_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL flush_after: stall/done got %b%b, expected 00", stall_a, done_a);
        else n_pass++;
        m2r_a = 1;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || rd_a !== 32'h00000001)
            $display("FAIL flush_data: done/data got %b %h, expected 1 00000001", done_a, rd_a);
        else n_pass++;
        tick();
        m2r_a = 0;
    endtask

    task automatic test_reset_mid();
        store_a(10'h020, 32'h00000002);
        mw_a = 1; addr_a = 10'h020; din_a = 32'h0BADF00D;
        tick();
        #2;
        n_checks++;
        if (stall_a !== 1'b1)
            $display("FAIL rstmid_pre: stall got %b, expected 1", stall_a);
        else n_pass++;
        rst = 0;
        #1;
        n_checks++;
        if (stall_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL rstmid_now: stall/done got %b%b, expected 00", stall_a, done_a);
        else n_pass++;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (stall_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL rstmid_hold: stall/done got %b%b, expected 00", stall_a, done_a);
        else n_pass++;
        mw_a = 0; din_a = '0;
        @(negedge clk);
        rst = 1;
        tick();
        m2r_a = 1;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || rd_a !== 32'h00000002)
            $display("FAIL rstmid_data: done/data got %b %h, expected 1 00000002", done_a, rd_a);
        else n_pass++;
        tick();
        m2r_a = 0;
    endtask

    task automatic test_back_to_back();
        logic es [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic ed [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        store_c(10'h100, 32'h11111111);
        store_c(10'h101, 32'h22222222);
        m2r_c = 1; addr_c = 10'h100;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) addr_c = 10'h101;
            @(negedge clk);
            n_checks++;
            if (stall_c !== es[i] || done_c !== ed[i])
                $display("FAIL b2b cyc%0d: stall/done got %b%b, expected %b%b",
                         i, stall_c, done_c, es[i], ed[i]);
            else n_pass++;
            if (ed[i]) begin
                n_checks++;
                if (rd_c !== ((i == 1) ? 32'h11111111 : 32'h22222222))
                    $display("FAIL b2b_data cyc%0d: got %h, expected %h", i, rd_c,
                             (i == 1) ? 32'h11111111 : 32'h22222222);
                else n_pass++;
            end
            tick();
        end
        m2r_c = 0;
    endtask

    task automatic test_simultaneous();
        m2r_a = 1; mw_a = 1; addr_a = 10'h001; din_a = 32'h00000077;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || stall_a !== 1'b0)
            $display("FAIL both_done: stall/done got %b%b, expected 01", stall_a, done_a);
        else n_pass++;
        tick();
        mw_a = 0; din_a = '0;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || rd_a !== 32'h00000077)
            $display("FAIL both_data: done/data got %b %h, expected 1 00000077", done_a, rd_a);
        else n_pass++;
        tick();
        m2r_a = 0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wait0();
        test_flush_idle();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, range 0..7: extra cycles each data-memory access occupies.
REQ-002 SHALL have parameter ADDR_W, default 10: word-address width; memory depth is 2**ADDR_W words of 32 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_to_reg_in  input  1  load request from the EXE_MEM register.
REQ-006 SHALL have port mem_write_in  input  1  store request from the EXE_MEM register.
REQ-007 SHALL have port dmem_addr_in  input  ADDR_W  word address.
REQ-008 SHALL have port dmem_in_in  input  32  store data.
REQ-009 SHALL have port flush  input  1  abort any pending access.
REQ-010 SHALL have port stall  output  1  high = upstream EXE_MEM en must be held low.
REQ-011 SHALL have port rd_data  output  32  load data, combinational read of the array at dmem_addr_in.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the cycle an access completes.

Function
REQ-013 SHALL define req = mem_to_reg_in | mem_write_in; when both are high, the access is a store.
REQ-014 SHALL implement FSM states IDLE and WAIT, plus a 3-bit down-counter cnt.
REQ-015 IDLE, req=1, WAIT_CYCLES=0: SHALL complete the access in the same cycle, with stall=0, done=1, and the store written at the closing edge.
REQ-016 IDLE, req=1, WAIT_CYCLES>0: SHALL set stall=1 and done=0, load cnt=WAIT_CYCLES, and move to WAIT.
REQ-017 WAIT, cnt>1: SHALL set stall=1 and decrement cnt.
REQ-018 WAIT, cnt=1: SHALL set stall=0 and done=1, write any store at the closing edge, and go to IDLE.
REQ-019 SHALL therefore hold stall high for exactly WAIT_CYCLES consecutive cycles per access, with done in the cycle after the last stall cycle.
REQ-020 rd_data SHALL reflect the array contents combinationally and is valid only in the done cycle of a load.
REQ-021 A request present in the IDLE cycle immediately after done SHALL start a new access, so back-to-back accesses have no bubble.
REQ-022 Each access SHALL perform at most one array write.
REQ-023 flush=1 in WAIT: SHALL go to IDLE with no write, with stall=0 and done=0 that cycle.
REQ-024 flush=1 in IDLE together with req: SHALL ignore the request, with no write, stall=0 and done=0.
REQ-025 Inputs SHALL be held stable by upstream while stall=1; the block does not latch them.
REQ-026 The address SHALL wrap modulo 2**ADDR_W, with no out-of-range condition.

Reset
REQ-027 While rst=0, the block SHALL force state=IDLE, cnt=0, stall=0 and done=0, asynchronously.
REQ-028 Reset mid-access SHALL discard the pending store.
REQ-029 Memory contents SHALL NOT be reset; rd_data is undefined until the location is written.
REQ-030 The first access SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, WAIT=1) and the cnt width constant (3).
REQ-032 The storage array SHALL be a sub-module dmem_array: 2**ADDR_W x 32, asynchronous read, synchronous write with a write enable.
REQ-033 mem_access SHALL contain only the FSM, the counter, and the write-enable/stall/done logic.

Verification
REQ-034 SHALL test a store followed by a load, WAIT_CYCLES=2: store 0xDEADBEEF to addr 0x005, then load 0x005 -> stall high 2 cycles each, done on cycle 3, rd_data=0xDEADBEEF.
REQ-035 SHALL test WAIT_CYCLES=0: store 0x12345678 to addr 0x3FF, then load it -> stall never high, done every cycle, rd_data=0x12345678.
REQ-036 SHALL test flush: store 0xAAAA5555 to addr 0x010 with flush pulsed in the 2nd stall cycle -> no done, addr 0x010 keeps its prior value 0x00000001.
REQ-037 SHALL test reset mid-access: rst low during WAIT of a store of 0x0BADF00D to addr 0x020 -> stall=0 immediately, and addr 0x020 keeps 0x00000002.
REQ-038 SHALL test back-to-back accesses: two loads held continuously, WAIT_CYCLES=1 -> stall pattern 1,0,1,0 and done pattern 0,1,0,1.
REQ-039 SHALL test simultaneous requests: mem_to_reg_in=mem_write_in=1 with data 0x00000077 to addr 0x001 -> the store occurs and a later load returns 0x00000077.
